// File: rtl/reg_writeback_queue_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue_pkg
// Shared definitions for the register-file write-back queue:
//   WBQ_AW / WBQ_DW  default register address / data widths
//   WBQ_NREGS        number of architectural registers (8)
//   WBQ_DEPTH        default queue depth
//   wb_entry_t       one queued write-back result {dst, data}
// ---------------------------------------------------------------------------
package reg_writeback_queue_pkg;

   localparam int WBQ_AW    = 3;
   localparam int WBQ_DW    = 8;
   localparam int WBQ_NREGS = 1 << WBQ_AW;
   localparam int WBQ_DEPTH = 4;

   typedef struct packed {
      logic [WBQ_AW-1:0] dst;
      logic [WBQ_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_wbq_fifo.sv
// ---------------------------------------------------------------------------
// wbq_fifo
// In-order storage for write-back results: entry array, head/tail pointers
// and occupancy count. Exposes the whole entry array plus a valid mask so the
// parent can run forwarding and pending-bitmap logic over queued entries.
//   clk, reset      clock, asynchronous active-low reset
//   flush           synchronous discard of all entries (beats push and pop)
//   push_valid/reg/data, push_ready   enqueue handshake (ready = not full)
//   pop             retire the head entry this cycle
//   head_reg/data   head entry contents
//   head            head pointer (oldest entry index)
//   ent_reg/data    full entry array
//   valid_mask      bit i set iff entry i lies inside the head..tail window
//   empty           queue holds no entries
// ---------------------------------------------------------------------------
module wbq_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 3,
   parameter int DW    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push_valid,
   input  logic [AW-1:0]                push_reg,
   input  logic [DW-1:0]                push_data,
   output logic                         push_ready,
   input  logic                         pop,
   output logic [AW-1:0]                head_reg,
   output logic [DW-1:0]                head_data,
   output logic [$clog2(DEPTH)-1:0]     head,
   output logic [DEPTH-1:0][AW-1:0]     ent_reg,
   output logic [DEPTH-1:0][DW-1:0]     ent_data,
   output logic [DEPTH-1:0]             valid_mask,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q;
   logic [PW-1:0] tail_q;
   logic [CW-1:0] count_q;
   logic          full;
   logic          do_push;
   logic          do_pop;
   logic [PW-1:0] offs;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign push_ready = ~full;
   // A full queue refuses pushes even when a pop frees a slot this cycle.
   assign do_push    = push_valid & ~full;
   assign do_pop     = pop & ~empty;

   assign head      = head_q;
   assign head_reg  = ent_reg[head_q];
   assign head_data = ent_data[head_q];

   // Entry i is live when its distance from head (mod DEPTH) is below count.
   always_comb begin
      offs       = '0;
      valid_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs          = PW'(i) - head_q;
         valid_mask[i] = ({1'b0, offs} < count_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         ent_reg  <= '0;
         ent_data <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            ent_reg[tail_q]  <= push_reg;
            ent_data[tail_q] <= push_data;
            tail_q           <= tail_q + 1'b1;
         end
         if (do_pop) begin
            head_q <= head_q + 1'b1;
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue
// Drives the register-file write port from an in-order queue of execute-stage
// results, retiring at most one write per cycle, and offers a forwarding
// lookup plus a pending bitmap over results not yet written.
//   clk, reset                 clock, asynchronous active-low reset
//   wb_valid/reg/data, wb_ready  result intake handshake
//   flush                      discard all queued results
//   rf_hold                    register-file port busy; suppresses retirement
//   RegWrite/Write_reg/Write_data  register-file write port
//   fwd_reg -> fwd_hit/fwd_data    newest queued value for a register
//   pending                    bit r set iff a queued result targets r
//   idle                       queue empty
// ---------------------------------------------------------------------------
module reg_writeback_queue
   import reg_writeback_queue_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int AW    = WBQ_AW,
   parameter int DW    = WBQ_DW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_reg,
   input  logic [DW-1:0]         wb_data,
   output logic                  wb_ready,
   input  logic                  flush,
   input  logic                  rf_hold,
   output logic                  RegWrite,
   output logic [AW-1:0]         Write_reg,
   output logic [DW-1:0]         Write_data,
   input  logic [AW-1:0]         fwd_reg,
   output logic                  fwd_hit,
   output logic [DW-1:0]         fwd_data,
   output logic [(1<<AW)-1:0]    pending,
   output logic                  idle
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]           head;
   logic [DEPTH-1:0][AW-1:0] ent_reg;
   logic [DEPTH-1:0][DW-1:0] ent_data;
   logic [DEPTH-1:0]        valid_mask;
   logic                    empty;
   logic [PW-1:0]           idx;

   wbq_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push_valid (wb_valid),
      .push_reg   (wb_reg),
      .push_data  (wb_data),
      .push_ready (wb_ready),
      .pop        (RegWrite),
      .head_reg   (Write_reg),
      .head_data  (Write_data),
      .head       (head),
      .ent_reg    (ent_reg),
      .ent_data   (ent_data),
      .valid_mask (valid_mask),
      .empty      (empty)
   );

   // The write issues in the same cycle the head is popped, so the head
   // entry still drives the port during a flush cycle.
   assign RegWrite = ~empty & ~rf_hold;
   assign idle     = empty;

   // Walk oldest to newest; a later match overrides, so the newest wins.
   always_comb begin
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (valid_mask[idx] && (ent_reg[idx] == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[idx];
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_mask[i]) begin
            pending[ent_reg[i]] = 1'b1;
         end
      end
   end

endmodule
